// File: rtl/uart_pkg.sv
// Shared definitions for the uart_mmio peripheral: register offsets, STATUS
// bit positions and the transmitter/receiver state encodings.
package uart_pkg;

  // Word offsets inside the 16-byte register window.
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;

  // STATUS register bit positions.
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_NE     = 2;
  localparam int ST_RX_OVF    = 3;
  localparam int ST_FRAME_ERR = 4;
  localparam int ST_IE_RX     = 5;
  localparam int ST_IE_TX     = 6;

  // Smallest divisor the bit timing logic supports.
  localparam int DIV_MIN = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO used for both the TX and RX byte queues.
// Ports:
//   clk, resetn      core clock, asynchronous active-low reset
//   push_i, wdata_i  write request and data; ignored when full unless popping
//   pop_i            read request; ignored when empty
//   rdata_o          current head entry (valid only when not empty)
//   full_o, empty_o  occupancy flags
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty when the low bits match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs and a programmable baud divisor.
// Registers (word offsets): 0 DATA, 1 STATUS, 2 DIV, 3 reserved (reads 0).
// Ports:
//   clk, resetn  core clock, asynchronous active-low reset
//   sel          decode hit for this peripheral's window
//   wr, rd       write / read strobes qualified by sel (wr wins if both)
//   addr         word offset
//   wdata        write data
//   rdata        registered read data, updated only by reads
//   rxd          asynchronous serial input
//   txd          serial output, idle high
//   irq          level interrupt (rx_not_empty & ie_rx) | (tx_empty & ie_tx)
module uart_mmio
  import uart_pkg::*;
#(
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int DIV_RESET = 868,
  parameter int DIV_W     = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic        wr,
  input  logic        rd,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rxd,
  output logic        txd,
  output logic        irq
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  // Bus decode
  logic wr_en, rd_en;
  assign wr_en = sel && wr;
  assign rd_en = sel && rd && !wr;

  // Control/status registers
  logic [DIV_W-1:0] div_q, div_d;
  logic             ie_rx_q, ie_rx_d, ie_tx_q, ie_tx_d;
  logic             ovf_q, ovf_d, ferr_q, ferr_d;
  logic [31:0]      rdata_q, rdata_d, status;

  // FIFO interfaces
  logic       tx_push, tx_pop, tx_full, tx_fifo_empty;
  logic [7:0] tx_head;
  logic       rx_push, rx_pop, rx_full, rx_fifo_empty;
  logic [7:0] rx_head, rx_shift_q, rx_shift_d;

  assign tx_push = wr_en && (addr == ADDR_DATA);
  assign rx_pop  = rd_en && (addr == ADDR_DATA);

  uart_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (wdata[7:0]),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_fifo_empty)
  );

  uart_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (rx_shift_d),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_fifo_empty)
  );

  // ---------------------------------------------------------------- TX path
  tx_state_t        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d, tx_start, tx_empty;

  assign tx_empty = tx_fifo_empty && (tx_state_q == TX_IDLE);

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so
    // no path through the case leaves it unassigned and infers a latch.
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_start   = 1'b0;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE:  tx_start = !tx_fifo_empty;
      TX_START: begin
        if (tx_cnt_q == ONE) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = tx_div_q;
          tx_bit_d   = 4'd0;
        end else tx_cnt_d = tx_cnt_q - ONE;
      end
      TX_DATA: begin
        if (tx_cnt_q == ONE) begin
          tx_cnt_d = tx_div_q;
          if (tx_bit_q == 4'd7) tx_state_d = TX_STOP;
          else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_shift_d = tx_shift_q >> 1;
          end
        end else tx_cnt_d = tx_cnt_q - ONE;
      end
      TX_STOP: begin
        if (tx_cnt_q == ONE) begin
          // Chain straight into the next frame when more data is queued.
          if (!tx_fifo_empty) tx_start = 1'b1;
          else                tx_state_d = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q - ONE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Frame start snapshots the divisor so a DIV write never disturbs a frame.
    if (tx_start) begin
      tx_pop     = 1'b1;
      tx_state_d = TX_START;
      tx_cnt_d   = div_q;
      tx_div_d   = div_q;
      tx_shift_d = tx_head;
    end
    // txd is registered from the next state so the pin never glitches.
    unique case (tx_state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = tx_shift_d[0];
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_W'(DIV_RESET);
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  assign txd = txd_q;

  // ---------------------------------------------------------------- RX path
  rx_state_t        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [3:0]       rx_bit_q, rx_bit_d;
  logic [1:0]       rx_sync_q;
  logic             rx_prev_q, rx_s, ovf_set, ferr_set;

  assign rx_s = rx_sync_q[1];

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ovf_set    = 1'b0;
    ferr_set   = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          // Half a bit later we are at the centre of the start bit.
          rx_state_d = RX_START;
          rx_cnt_d   = div_q >> 1;
          rx_div_d   = div_q;
        end
      end
      RX_START: begin
        if (rx_cnt_q == ONE) begin
          if (rx_s) rx_state_d = RX_IDLE;  // false start
          else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = rx_div_q;
            rx_bit_d   = 4'd0;
          end
        end else rx_cnt_d = rx_cnt_q - ONE;
      end
      RX_DATA: begin
        if (rx_cnt_q == ONE) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q;
          if (rx_bit_q == 4'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 4'd1;
        end else rx_cnt_d = rx_cnt_q - ONE;
      end
      RX_STOP: begin
        if (rx_cnt_q == ONE) begin
          if (rx_s) begin
            // The FIFO drops the byte itself when full and not being popped.
            rx_push    = 1'b1;
            ovf_set    = rx_full && !(rx_pop && !rx_fifo_empty);
            rx_state_d = RX_IDLE;
          end else begin
            ferr_set   = 1'b1;
            rx_state_d = RX_WAIT_IDLE;
          end
        end else rx_cnt_d = rx_cnt_q - ONE;
      end
      RX_WAIT_IDLE: if (rx_s) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_W'(DIV_RESET);
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_sync_q  <= {rx_sync_q[0], rxd};
      rx_prev_q  <= rx_s;
    end
  end

  // ------------------------------------------------------- Register file
  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_NE]     = !rx_fifo_empty;
    status[ST_RX_OVF]    = ovf_q;
    status[ST_FRAME_ERR] = ferr_q;
    status[ST_IE_RX]     = ie_rx_q;
    status[ST_IE_TX]     = ie_tx_q;
  end

  always_comb begin
    div_d   = div_q;
    ie_rx_d = ie_rx_q;
    ie_tx_d = ie_tx_q;
    ovf_d   = ovf_q;
    ferr_d  = ferr_q;
    rdata_d = rdata_q;
    if (wr_en && addr == ADDR_STATUS) begin
      if (wdata[ST_RX_OVF])    ovf_d  = 1'b0;
      if (wdata[ST_FRAME_ERR]) ferr_d = 1'b0;
      ie_rx_d = wdata[ST_IE_RX];
      ie_tx_d = wdata[ST_IE_TX];
    end
    // Hardware set events follow the clears so a coincident set wins.
    if (ovf_set)  ovf_d  = 1'b1;
    if (ferr_set) ferr_d = 1'b1;
    if (wr_en && addr == ADDR_DIV) begin
      div_d = (wdata[DIV_W-1:0] < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : wdata[DIV_W-1:0];
    end
    if (rd_en) begin
      unique case (addr)
        ADDR_DATA:   rdata_d = rx_fifo_empty ? 32'd0 : {24'd0, rx_head};
        ADDR_STATUS: rdata_d = status;
        ADDR_DIV:    rdata_d = 32'(div_q);
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q   <= DIV_W'(DIV_RESET);
      ie_rx_q <= 1'b0;
      ie_tx_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      div_q   <= div_d;
      ie_rx_q <= ie_rx_d;
      ie_tx_q <= ie_tx_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = (!rx_fifo_empty && ie_rx_q) || (tx_empty && ie_tx_q);

  // Upper write-data bits have no register behind them.
  generate
    if (DIV_W < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^wdata[31:DIV_W];
    end
  endgenerate

endmodule

// File: tb/tb_uart_mmio.sv
// Directed self-checking bench for uart_mmio with default parameters.
module tb_uart_mmio;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        sel = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        txd, irq, rxd_line;
  logic        loop_en = 1'b0, rxd_drv = 1'b1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  assign rxd_line = loop_en ? txd : rxd_drv;

  uart_mmio dut (
    .clk    (clk),
    .resetn (resetn),
    .sel    (sel),
    .wr     (wr),
    .rd     (rd),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rxd    (rxd_line),
    .txd    (txd),
    .irq    (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Independent txd frame decoder: records start cycle and byte of each frame.
  int         mon_div = 4;
  int         mon_start[$];
  logic [7:0] mon_byte[$];
  int         mon_stop_bad = 0;

  always begin : tx_monitor
    int         s;
    logic [7:0] b;
    @(negedge clk);
    if (resetn === 1'b1 && txd === 1'b0) begin
      s = cyc;
      repeat (mon_div + mon_div / 2) @(negedge clk);
      for (int j = 0; j < 8; j++) begin
        b[j] = txd;
        if (j < 7) repeat (mon_div) @(negedge clk);
      end
      repeat (mon_div) @(negedge clk);
      if (txd !== 1'b1) mon_stop_bad++;
      mon_start.push_back(s);
      mon_byte.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; rd = 1'b1; addr = a;
    @(negedge clk);
    sel = 1'b0; rd = 1'b0;
    d = rdata;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
    rxd_drv = 1'b0;
    repeat (div) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rxd_drv = b[j];
      repeat (div) @(negedge clk);
    end
    rxd_drv = stop;
    repeat (div) @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] r;
    logic [39:0] pat, exp_pat;
    logic [7:0]  d55;
    int          b, gaps, berr;

    // Reset state
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst_rdata", rdata, 0);
    check("rst_txd", txd, 1);
    check("rst_irq", irq, 0);
    bus_read(ADDR_STATUS, r); check("rst_status", r, 32'h02);
    bus_read(ADDR_DIV, r);    check("rst_div", r, 868);

    // Divisor clamp
    bus_write(ADDR_DIV, 32'd1);
    bus_read(ADDR_DIV, r); check("div_clamp", r, 4);

    // Single frame at div=4, bit-exact waveform
    mon_div = 4;
    d55 = 8'h55;
    for (int k = 0; k < 40; k++) begin
      b = k / 4;
      exp_pat[k] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d55[b-1];
    end
    bus_write(ADDR_DATA, 32'h55);
    check("tx_high_at_write", txd, 1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      pat[k] = txd;
    end
    check("tx_wave_0x55", pat, exp_pat);
    bus_read(ADDR_STATUS, r); check("tx_empty_after_frame", r, 32'h02);

    // Loopback receive of 0xA3 at div=8, with RX interrupt
    loop_en = 1'b1;
    mon_div = 8;
    bus_write(ADDR_DIV, 32'd8);
    bus_write(ADDR_DATA, 32'hA3);
    repeat (100) @(negedge clk);
    bus_read(ADDR_STATUS, r); check("rx_ne_status", r, 32'h06);
    bus_write(ADDR_STATUS, 32'h20);
    check("irq_rx_on", irq, 1);
    bus_read(ADDR_DATA, r); check("rx_data_a3", r, 32'h0000_00A3);
    check("irq_rx_off", irq, 0);
    bus_read(ADDR_STATUS, r); check("rx_empty_status", r, 32'h22);
    bus_write(ADDR_STATUS, 32'h00);
    bus_read(ADDR_DATA, r); check("rd_empty_zero", r, 0);

    // 3-clock glitch is a false start
    loop_en = 1'b0;
    rxd_drv = 1'b0;
    repeat (3) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (100) @(negedge clk);
    bus_read(ADDR_STATUS, r); check("glitch_ignored", r, 32'h02);

    // Framing error, then clear
    send_frame(8'h3C, 1'b0, 8);
    repeat (30) @(negedge clk);
    bus_read(ADDR_STATUS, r); check("frame_err_set", r, 32'h12);
    bus_write(ADDR_STATUS, 32'h10);
    bus_read(ADDR_STATUS, r); check("frame_err_clr", r, 32'h02);

    // TX FIFO fill/drop, back-to-back frames and RX overflow via loopback
    loop_en = 1'b1;
    mon_start.delete();
    mon_byte.delete();
    mon_stop_bad = 0;
    bus_write(ADDR_DATA, 32'h00);
    repeat (4) @(negedge clk);
    for (int i = 1; i <= 16; i++) bus_write(ADDR_DATA, 32'(i));
    bus_read(ADDR_STATUS, r); check("tx_full_after_16", r, 32'h01);
    bus_write(ADDR_DATA, 32'h11);
    repeat (1500) @(negedge clk);
    bus_read(ADDR_STATUS, r); check("rx_ovf_status", r, 32'h0E);
    check("tx_frame_count", mon_start.size(), 17);
    gaps = 0;
    berr = 0;
    for (int i = 0; i < mon_start.size(); i++) begin
      if (mon_byte[i] !== 8'(i)) berr++;
      if (i > 0 && (mon_start[i] - mon_start[i-1]) != 80) gaps++;
    end
    check("tx_bytes_in_order", berr, 0);
    check("tx_no_idle_gap", gaps, 0);
    check("tx_stop_bits", mon_stop_bad, 0);
    for (int i = 0; i < 16; i++) begin
      bus_read(ADDR_DATA, r);
      check($sformatf("rx_fifo_%0d", i), r, 32'(i));
    end
    bus_read(ADDR_STATUS, r); check("rx_drained", r, 32'h0A);
    bus_write(ADDR_STATUS, 32'h08);
    bus_read(ADDR_STATUS, r); check("rx_ovf_clr", r, 32'h02);

    // Reset in the middle of a frame
    loop_en = 1'b0;
    bus_write(ADDR_DIV, 32'd100);
    mon_div = 100;
    bus_write(ADDR_DATA, 32'h00);
    bus_write(ADDR_DATA, 32'h00);
    repeat (150) @(negedge clk);
    check("tx_midframe_low", txd, 0);
    #2 resetn = 1'b0;
    #1 check("rst_async_txd", txd, 1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("rst2_rdata", rdata, 0);
    repeat (5) @(negedge clk);
    check("rst2_txd_idle", txd, 1);
    bus_read(ADDR_STATUS, r); check("rst2_status", r, 32'h02);
    bus_read(ADDR_DIV, r);    check("rst2_div", r, 868);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART peripheral that supersedes the single-byte, TX-only serial port on the SCR1 data bus.
- Has parametrised TX and RX FIFOs, a full-duplex 8N1 transmitter and receiver, and a runtime-programmable baud divisor.
- Runs entirely in the core clock domain, so no separate serial PLL output is needed.
- Sits behind the top-level dmem address decode. Status bit 0 keeps the legacy meaning "TX cannot accept a byte", so existing polling firmware runs unchanged.

Parameters:
- TX_DEPTH, 16: TX FIFO entries; power of two, minimum 2.
- RX_DEPTH, 16: RX FIFO entries; power of two, minimum 2.
- DIV_RESET, 868: reset value of the baud divisor in clocks per bit (100 MHz / 115200). Must be at least 4.
- DIV_W, 16: width of the divisor register.

Ports:
- clk  in  1  core clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- sel  in  1  the decode hit this peripheral's 16-byte window.
- wr  in  1  write strobe, qualified by sel.
- rd  in  1  read strobe, qualified by sel.
- addr  in  2  word offset: 0 DATA, 1 STATUS, 2 DIV, 3 reserved.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- rxd  in  1  serial input, asynchronous to clk.
- txd  out  1  serial output, idle high.
- irq  out  1  level interrupt: (rx_not_empty & ie_rx) | (tx_empty & ie_tx).

Behaviour:
- Reset values:
  - txd=1, rdata=0, irq=0.
  - Both FIFOs empty; div=DIV_RESET; ie_rx=ie_tx=0.
  - Sticky flags rx_ovf and frame_err = 0; TX and RX FSMs in IDLE.
  - Reset mid-frame aborts the frame immediately; txd returns to 1 asynchronously.
- Bus timing:
  - A write takes effect at the clock edge where sel&wr is high.
  - For a read, rdata is valid on the cycle after sel&rd and holds until the next read.
  - wr and rd asserted together is illegal; wr wins and rdata does not update.
- DATA register:
  - Write pushes wdata[7:0] into the TX FIFO. A write while the FIFO is full is dropped.
  - Read returns {24'b0, head} and pops the RX FIFO. A read while empty returns 0 and does not pop.
- STATUS register, read layout:
  - bit0 tx_full, bit1 tx_empty (FIFO empty and shifter idle), bit2 rx_not_empty.
  - bit3 rx_ovf, bit4 frame_err, bit5 ie_rx, bit6 ie_tx, others 0.
- STATUS register, write behaviour:
  - wdata[3]=1 clears rx_ovf; wdata[4]=1 clears frame_err.
  - wdata[5] and wdata[6] load ie_rx and ie_tx.
  - A clear and a new set event in the same cycle: set wins.
- DIV register:
  - Reads and writes div[DIV_W-1:0]. A written value below 4 is clamped to 4.
  - A write takes effect at the next frame start; a frame already in progress keeps the old divisor.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - Leaves IDLE when the FIFO is non-empty, popping the head byte in that same cycle.
  - Each state lasts exactly div clocks.
  - DATA sends 8 bits LSB first, driven from a registered shifter.
  - STOP drives 1. If the FIFO is non-empty at the end of STOP, the FSM goes straight to START with no idle gap.
- TX FIFO push and pop in the same cycle while full: both succeed and the count is unchanged.
- RX synchroniser and start detect:
  - rxd passes a two-flop synchroniser, initialised to 1.
  - RX IDLE waits for a synchronised falling edge, then waits div/2 clocks (integer divide, floor).
  - If the line is high at that point, the event is a false start and the FSM returns to IDLE.
- RX data and stop handling:
  - Otherwise sample every div clocks: 8 data bits, LSB first, then the stop bit.
  - Stop bit = 1: push the byte. If the FIFO is full, drop the byte and set rx_ovf.
  - Stop bit = 0: set frame_err, discard the byte, and wait for the line to be high before returning to IDLE.
- RX FIFO push and pop in the same cycle while full: the pop frees the slot, the push succeeds, and rx_ovf is not set.
- FIFO implementation:
  - Pointers are log2(DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs differ and the low bits are equal; empty = pointers equal.
- Bit counters are 4 bits; the baud counter is DIV_W bits and counts down to 1.

Decomposition:
- Shared package uart_pkg holds:
  - Register offsets: ADDR_DATA=0, ADDR_STATUS=1, ADDR_DIV=2.
  - STATUS bit index constants.
  - Enum typedefs tx_state_t {IDLE,START,DATA,STOP} and rx_state_t {IDLE,START,DATA,STOP,WAIT_IDLE}.
- One sub-module, uart_fifo (params DEPTH, WIDTH=8), is instantiated once for TX and once for RX.

Test Plan:
- div=4: write DATA=0x55.
  - Required: txd goes low 1 clock after the write, then 0x55 appears LSB first with each bit held 4 clocks, then stop=1.
  - STATUS.tx_empty reads 1 after 40 clocks.
- Write 17 bytes with TX_DEPTH=16 and the shifter busy.
  - Required: the 17th byte is dropped; tx_full=1 after the 16th accepted byte.
  - All 16 accepted bytes are sent back-to-back with no idle gap.
- Loop txd to rxd at div=8 and send 0xA3.
  - Required: rx_not_empty=1 after the frame; DATA read returns 0x000000A3; rx_not_empty then reads 0.
- Drive a 3-clock low glitch on rxd at div=8.
  - Required: no byte is pushed and frame_err stays 0.
- Send a frame with stop=0.
  - Required: frame_err=1 and the FIFO is unchanged.
  - Writing STATUS=0x10 clears frame_err.
- Receive 17 bytes with no reads.
  - Required: rx_ovf=1 and the first 16 bytes are read back in order.
- Assert resetn=0 mid TX frame.
  - Required: txd=1 immediately, all FIFOs empty, div=DIV_RESET.
